conv_encoder: RTL and testbench

CONV_ENCODER -- requirements
Module: conv_encoder

---
 rtl/conv_encoder.sv | 81 ++++++++
 tb/tb_conv_encoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder (802.11a), serialising A then B at twice the bit rate.
// Latency: Output is combinational from Input; the state shifts once per data bit at the end of the B slot.
// Backpressure: none. The optional CONV_ENCODER_PUNCTURE_EN build adds Rate/OutValid to mark stolen slots.
module conv_encoder #(
  parameter logic [6:0] G0 = 7'o133,
  parameter logic [6:0] G1 = 7'o171
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Input,
`ifdef CONV_ENCODER_PUNCTURE_EN
  input  logic [1:0] Rate,
  output logic       OutValid,
`endif
  output logic       Output,
  output logic [1:6] x
);

  logic phase;
  logic bit_a;
  logic bit_b;
  logic coded;

  // Bit 6 of the generator taps the live input; bit 6-k taps x[k].
  function automatic logic tap_xor(input logic [6:0] g, input logic din, input logic [1:6] s);
    logic acc;
    acc = g[6] & din;
    for (int k = 1; k <= 6; k++) begin
      acc = acc ^ (g[6-k] & s[k]);
    end
    return acc;
  endfunction

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      phase <= 1'b0;
      x     <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        x <= {Input, x[1:5]};
      end
    end
  end

  assign bit_a = tap_xor(G0, Input, x);
  assign bit_b = tap_xor(G1, Input, x);
  assign coded = phase ? bit_b : bit_a;

`ifdef CONV_ENCODER_PUNCTURE_EN
  logic [1:0] bit_idx;
  logic [1:0] rate_q;
  logic       stolen;

  // bit_idx 0 is the first bit of a period; Rate is captured only as that bit completes.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      bit_idx <= 2'd0;
      rate_q  <= 2'b00;
    end else if (phase) begin
      case (bit_idx)
        2'd0: begin
          rate_q  <= Rate;
          bit_idx <= (Rate == 2'b01 || Rate == 2'b10) ? 2'd1 : 2'd0;
        end
        2'd1:    bit_idx <= (rate_q == 2'b10) ? 2'd2 : 2'd0;
        default: bit_idx <= 2'd0;
      endcase
    end
  end

  assign stolen = (bit_idx == 2'd1 && phase && (rate_q == 2'b01 || rate_q == 2'b10)) ||
                  (bit_idx == 2'd2 && !phase && rate_q == 2'b10);

  assign Output   = stolen ? 1'b0 : coded;
  assign OutValid = Reset & ~stolen;
`else
  assign Output = coded;
`endif

endmodule

// File: tb/tb_conv_encoder.sv
// Directed bench for conv_encoder: scoreboard of expected {Output, x} per clock slot.
module tb_conv_encoder;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Input;
  logic       Output;
  logic [1:6] x;
`ifdef CONV_ENCODER_PUNCTURE_EN
  logic [1:0] Rate;
  logic       OutValid;
`endif

  always #5 Clock = ~Clock;

  conv_encoder dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Input    (Input),
`ifdef CONV_ENCODER_PUNCTURE_EN
    .Rate     (Rate),
    .OutValid (OutValid),
`endif
    .Output   (Output),
    .x        (x)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [6:0] exp_q[$];
  logic [1:6] ref_x;

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock slot: drive, push expectation, compare at the falling edge, return at posedge+1.
  task automatic slot(input logic din, input logic exp_out, input string tag);
    logic [6:0] e;
    Input = din;
    exp_q.push_back({exp_out, ref_x});
    @(negedge Clock);
    e = exp_q.pop_front();
    check(tag, {Output, x}, e);
    @(posedge Clock);
    #1;
  endtask

  task automatic data_bit(input logic din, input logic exp_a, input logic exp_b, input string tag);
    slot(din, exp_a, tag);
    slot(din, exp_b, tag);
    ref_x = {din, ref_x[1:5]};
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    ref_x = '0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
  endtask

  task automatic run_ones(input int nbits, input string tag);
    logic [15:0] pat;
    pat = 16'b1110011010001111;
    for (int b = 0; b < nbits; b++) begin
      data_bit(1'b1, pat[15-2*b], pat[14-2*b], tag);
    end
  endtask

`ifdef CONV_ENCODER_PUNCTURE_EN
  task automatic pslot(input logic exp_vld, input logic exp_out, input string tag);
    logic [6:0] e;
    Input = 1'b1;
    exp_q.push_back({5'b0, exp_vld, exp_out});
    @(negedge Clock);
    e = exp_q.pop_front();
    check(tag, {5'b0, OutValid, Output}, e);
    @(posedge Clock);
    #1;
  endtask
`endif

  initial begin
    logic [15:0] imp;
    logic [5:0]  vld6;
    logic [3:0]  vld4;

    Reset = 1'b0;
    Input = 1'b1;
    ref_x = '0;
`ifdef CONV_ENCODER_PUNCTURE_EN
    Rate = 2'b00;
`endif
    #2;
    check("reset_in1", {Output, x}, {1'b1, 6'b000000});
    Input = 1'b0;
    #1;
    check("reset_in0", {Output, x}, {1'b0, 6'b000000});
`ifdef CONV_ENCODER_PUNCTURE_EN
    check("reset_outvalid", {6'b0, OutValid}, 7'b0);
`endif

    // Constant ones from reset.
    do_reset();
    run_ones(8, "ones");

    // All-zero input keeps the encoder silent.
    do_reset();
    for (int b = 0; b < 10; b++) data_bit(1'b0, 1'b0, 1'b0, "zeros");

    // Single one: impulse response plus the one-hot walk through x.
    do_reset();
    imp = 16'b1101111100101100;
    for (int b = 0; b < 8; b++) data_bit(b == 0, imp[15-2*b], imp[14-2*b], "impulse");

    // Reset during a B slot, asynchronously, then a clean restart.
    do_reset();
    run_ones(5, "pre_rst_b");
    slot(1'b1, 1'b0, "pre_rst_b_a");
    Reset = 1'b0;
    #1;
    check("rst_b_async", {Output, x}, {1'b1, 6'b000000});
    ref_x = '0;
    @(posedge Clock);
    #1;
    check("rst_b_held", {Output, x}, {1'b1, 6'b000000});
    Reset = 1'b1;
    run_ones(8, "post_rst_b");

    // Reset during an A slot with Input low.
    run_ones(0, "noop");
    Input = 1'b0;
    #1;
    Reset = 1'b0;
    #1;
    check("rst_a_async", {Output, x}, {1'b0, 6'b000000});
    ref_x = '0;
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    run_ones(3, "post_rst_a");

`ifdef CONV_ENCODER_PUNCTURE_EN
    Rate = 2'b10;
    do_reset();
    vld6 = 6'b111001;
    for (int c = 0; c < 6; c++) pslot(vld6[5-c], vld6[5-c], "punct_3_4");

    Rate = 2'b01;
    do_reset();
    vld4 = 4'b1110;
    for (int c = 0; c < 4; c++) pslot(vld4[3-c], vld4[3-c], "punct_2_3");
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
